// File: rtl/spi_word_slave_if.sv
// spi_word_slave_if
//   Bus bundle for the SPI word slave. Serial clock and reset stay outside
//   as plain ports on the slave module.
//   Signals:
//     MOSI, CS           serial data in (MSB first) / frame enable (active high)
//     MISO               registered serial data out
//     TX_DATA, TX_ACK    next word to transmit / 1-cycle "TX_DATA sampled" pulse
//     RX_DATA, RX_VALID  last accepted received word / unconsumed-word flag
//     RX_READY           consumer accepts RX_DATA when RX_VALID=1
//     OVERRUN, CLR_OVR   sticky dropped-word flag / clear request
//     LED                low LED_W bits of the last accepted word
//     WORD_CNT           wrapping count of accepted words
//   Modports: slave (the SPI word slave), master (SPI host + consumer side).
interface spi_word_slave_if #(
  parameter int DATA_W = 8,
  parameter int LED_W  = 4,
  parameter int CNT_W  = 8
);
  logic              MOSI;
  logic              CS;
  logic              MISO;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_ACK;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              OVERRUN;
  logic              CLR_OVR;
  logic [LED_W-1:0]  LED;
  logic [CNT_W-1:0]  WORD_CNT;

  modport slave (
    input  MOSI, CS, TX_DATA, RX_READY, CLR_OVR,
    output MISO, TX_ACK, RX_DATA, RX_VALID, OVERRUN, LED, WORD_CNT
  );

  modport master (
    output MOSI, CS, TX_DATA, RX_READY, CLR_OVR,
    input  MISO, TX_ACK, RX_DATA, RX_VALID, OVERRUN, LED, WORD_CNT
  );
endinterface

// File: rtl/spi_word_slave.sv
// spi_word_slave
//   SPI slave moving DATA_W-bit words MSB first, one bit per SLK posedge.
//   Received words go to a valid/ready port; transmit words are loaded at the
//   first bit of every word, so back-to-back words within one CS frame work.
//   Ports:
//     SLK    serial clock, all logic on posedge
//     RST_N  asynchronous active-low reset
//     bus    spi_word_slave_if.slave (see interface header for members)
//   Build option:
//     SPI_LOOPBACK_EN  defined: transmit word comes from RX_DATA and TX_DATA
//                      is ignored (TX_ACK still pulses on each load).
//
//   state | meaning
//   IDLE  | CS=0: bit counter held at 0, MISO low, partial word discarded
//   SHIFT | CS=1: shift one bit in and out per edge, cnt walks 0..DATA_W-1
module spi_word_slave #(
  parameter int DATA_W = 8,
  parameter int LED_W  = 4,
  parameter int CNT_W  = 8
) (
  input logic             SLK,
  input logic             RST_N,
  spi_word_slave_if.slave bus
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            mode;
  logic [CW-1:0]     cnt;
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] tx_src;
  logic [DATA_W-1:0] rx_word;
  logic              complete;
  logic              accept;
  logic              drop;

  // The frame state follows CS directly; a CS drop aborts the word on the
  // very next edge without waiting for a registered state change.
  assign mode = bus.CS ? SHIFT : IDLE;

`ifdef SPI_LOOPBACK_EN
  logic unused_tx_data;
  assign tx_src         = bus.RX_DATA;
  assign unused_tx_data = ^bus.TX_DATA;
`else
  assign tx_src = bus.TX_DATA;
`endif

  // Only DATA_W-1 bits are kept; the final bit is taken straight from MOSI.
  assign rx_word  = {rx_sh, bus.MOSI};
  assign complete = bus.CS && (cnt == LAST);
  assign accept   = complete && (!bus.RX_VALID || bus.RX_READY);
  assign drop     = complete && !accept;

  always_ff @(posedge SLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt          <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      bus.MISO     <= 1'b0;
      bus.TX_ACK   <= 1'b0;
      bus.RX_DATA  <= '0;
      bus.RX_VALID <= 1'b0;
      bus.OVERRUN  <= 1'b0;
      bus.LED      <= '0;
      bus.WORD_CNT <= '0;
    end else begin
      case (mode)
        IDLE: begin
          cnt        <= '0;
          bus.MISO   <= 1'b0;
          bus.TX_ACK <= 1'b0;
        end
        SHIFT: begin
          rx_sh <= rx_word[DATA_W-2:0];
          cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
          if (cnt == '0) begin
            bus.MISO   <= tx_src[DATA_W-1];
            tx_sh      <= tx_src << 1;
            bus.TX_ACK <= 1'b1;
          end else begin
            bus.MISO   <= tx_sh[DATA_W-1];
            tx_sh      <= tx_sh << 1;
            bus.TX_ACK <= 1'b0;
          end
        end
        default: begin
          cnt        <= '0;
          bus.MISO   <= 1'b0;
          bus.TX_ACK <= 1'b0;
        end
      endcase

      // Consumer handshake runs regardless of CS; a completion in the same
      // cycle as RX_READY replaces the word and keeps RX_VALID high.
      if (accept) begin
        bus.RX_DATA  <= rx_word;
        bus.LED      <= rx_word[LED_W-1:0];
        bus.RX_VALID <= 1'b1;
        bus.WORD_CNT <= bus.WORD_CNT + 1'b1;
      end else if (!complete && bus.RX_VALID && bus.RX_READY) begin
        bus.RX_VALID <= 1'b0;
      end

      // A drop in the same cycle as a clear request leaves the flag set.
      if (drop)
        bus.OVERRUN <= 1'b1;
      else if (bus.CLR_OVR)
        bus.OVERRUN <= 1'b0;
    end
  end

endmodule
